// File: rtl/edge_line_buffer.sv
// Two-row sliding-window line buffer: a 2-word current-row stage, a DEPTH-entry
// circular RAM delay line and a 2-word previous-row stage, all advancing on write_en.
module edge_line_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 76
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] w5,
  output logic [WIDTH-1:0] w4,
  output logic [WIDTH-1:0] w3,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             window_valid
);

  localparam int LINE = DEPTH + 2;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(LINE + 3) + 1;

  // Handshake: write_en alone qualifies data_in; the block always accepts it,
  // and every piece of state (stages, addr, counter) advances only on write_en.

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] w5_q, w4_q, w3_q, w2_q;
  logic [WIDTH-1:0] w3_d;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, valid_q;
  logic             primed;

  always_comb begin
    rd_data = mem[addr_q];
    // RAM is never reset; entries only hold real data once DEPTH words entered.
    primed  = (count_q >= CW'(DEPTH));
    w3_d    = primed ? rd_data : '0;
    addr_d  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    count_d = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w5_q    <= '0;
      w4_q    <= '0;
      w3_q    <= '0;
      w2_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (write_en) begin
      w5_q    <= data_in;
      w4_q    <= w5_q;
      w3_q    <= w3_d;
      w2_q    <= w3_q;
      addr_q  <= addr_d;
      count_q <= count_d;
      ready_q <= (count_d >= CW'(LINE));
      valid_q <= (count_d >= CW'(LINE + 2));
    end
  end

  // Read-before-write: this cycle's read sees the word stored DEPTH writes ago.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr_q] <= w4_q;
    end
  end

  assign w5           = w5_q;
  assign w4           = w4_q;
  assign w3           = w3_q;
  assign w2           = w2_q;
  assign data_out     = w2_q;
  assign ready        = ready_q;
  assign window_valid = valid_q;

endmodule

// File: tb/tb_edge_line_buffer.sv
// Directed self-checking bench for edge_line_buffer: window contents, priming flags,
// stalls, address wrap and asynchronous mid-stream reset.
module tb_edge_line_buffer;

  localparam int W  = 32;
  localparam int VW = 5 * W + 2;

  logic         clk;
  logic         rst_n;
  logic         write_en;
  logic [W-1:0] data_in;
  logic [W-1:0] w5, w4, w3, w2, data_out;
  logic         ready, window_valid;

  int n_checks;
  int n_fail;

  logic [VW-1:0] got;
  logic [VW-1:0] exp;

  edge_line_buffer #(.WIDTH(32), .DEPTH(76)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en     (write_en),
    .data_in      (data_in),
    .w5           (w5),
    .w4           (w4),
    .w3           (w3),
    .w2           (w2),
    .data_out     (data_out),
    .ready        (ready),
    .window_valid (window_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // D[k] of a stream starting at value base, zero for k <= 0
  function automatic logic [W-1:0] d_val(input int base, input int k);
    if (k <= 0) return '0;
    return W'(base + k - 1);
  endfunction

  // Expected window after n accepted writes of a stream starting at base
  function automatic logic [VW-1:0] exp_vec(input int base, input int n);
    logic [W-1:0] e2;
    e2 = d_val(base, n - 79);
    return {d_val(base, n), d_val(base, n - 1), d_val(base, n - 78), e2, e2,
            (n >= 78) ? 1'b1 : 1'b0, (n >= 80) ? 1'b1 : 1'b0};
  endfunction

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    write_en = 1'b0;
    data_in  = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  task automatic do_write(input logic [W-1:0] d);
    @(negedge clk);
    write_en = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle(input logic [W-1:0] d);
    @(negedge clk);
    write_en = 1'b0;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    got = {w5, w4, w3, w2, data_out, ready, window_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_idle_after_reset();
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      do_idle((i % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678);
      got = {w5, w4, w3, w2, data_out, ready, window_valid};
      exp = '0;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  // Writes 1..100 from reset, checking the full window after every write.
  task automatic test_fill();
    apply_reset();
    for (int n = 1; n <= 100; n++) begin
      do_write(W'(n));
      got = {w5, w4, w3, w2, data_out, ready, window_valid};
      exp = exp_vec(1, n);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fill n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  // 22-cycle stall after write 100, then resume with write 101.
  task automatic test_stall();
    for (int i = 0; i < 22; i++) begin
      do_idle(32'hDEAD_0000 + W'(i));
      n_checks++;
      if (w5 !== 32'd100 || w3 !== 32'd22) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d w5=%0d w3=%0d exp w5=100 w3=22", i, w5, w3);
      end
    end
    do_write(32'd101);
    n_checks++;
    if (w5 !== 32'd101 || w3 !== 32'd23) begin
      n_fail++;
      $display("FAIL stall_resume w5=%0d w3=%0d exp w5=101 w3=23", w5, w3);
    end
  endtask

  // Continue the stream to write 300, across several address wraps.
  task automatic test_back_to_back();
    for (int n = 102; n <= 300; n++) begin
      do_write(W'(n));
      got = {w5, w4, w3, w2, data_out, ready, window_valid};
      exp = exp_vec(1, n);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stream n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int n = 1; n <= 150; n++) do_write(W'(n));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = {w5, w4, w3, w2, data_out, ready, window_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    write_en = 1'b0;
    rst_n    = 1'b1;
    for (int n = 1; n <= 82; n++) begin
      do_write(W'(999 + n));
      got = {w5, w4, w3, w2, data_out, ready, window_valid};
      exp = exp_vec(1000, n);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL refill n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_alternate();
    int n;
    apply_reset();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        n++;
        do_write(W'(4999 + n));
      end else begin
        do_idle(32'hA5A5_A5A5);
      end
      got = {w5, w4, w3, w2, data_out, ready, window_valid};
      exp = exp_vec(5000, n);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL alternate cyc=%0d n=%0d got=%h exp=%h", i, n, got, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    write_en = 1'b0;
    data_in  = '0;
    test_reset();
    test_idle_after_reset();
    test_fill();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
